col_stream_sequencer: RTL and testbench
=======================================

// Module: col_stream_sequencer
// PURPOSE
// Next-generation column streamer between the per-mode frame generators and hub75 driver.
// Each beat carries NUM_CHANNELS columns. Channel c holds panel column idx + c*SCAN_RATE.
// Per dtheta, sweeps idx 0..SCAN_RATE-1 and skips indices that col_calc masks off.
// Waits for pipelined sources. Hands each beat to the hub75 driver over a valid/ready handshake.
// Restarts cleanly when dtheta changes mid-sweep.
// PARAMETERS
// ROTATIONAL_RES  256  rotation slots per revolution; dtheta width = $clog2(ROTATIONAL_RES)
// NUM_ROWS        64   pixels per column
// SCAN_RATE       32   indices per sweep; IW = $clog2(SCAN_RATE)
// RGB_RES         9    bits per pixel
// NUM_CHANNELS    2    columns per beat; CW = $clog2(NUM_CHANNELS*SCAN_RATE)
// NUM_SOURCES     4    selectable frame generators (cylinder/sphere/cube/boids); MW = $clog2(NUM_SOURCES)
// SRC_LATENCY     2    cycles from src_col_idx_out change to valid src_data_in (>=0)
// PORTS
// clk_in           in   1        system clock
// rst_n_in         in   1        asynchronous, active-low reset
// mode_in          in   MW       source select; sampled only at sweep start
// loop_en_in       in   1        1: restart sweep immediately; 0: wait for dtheta change
// dtheta_in        in   log2 RR  current rotation slot
// col_mask_in      in   NUM_CHANNELS*SCAN_RATE  bit k=1: panel column k visible at dtheta_in
// src_col_idx_out  out  IW       index presented to all sources
// src_data_in      in   NUM_SOURCES*NUM_CHANNELS*NUM_ROWS*RGB_RES  generator outputs, [s][c][row]
// hub75_ready_in   in   1        level ready from hub75 driver
// data_valid_out   out  1        beat valid
// columns_out      out  NUM_CHANNELS*NUM_ROWS*RGB_RES  beat data [c][row]
// col_num_out      out  NUM_CHANNELS*CW  panel column number per channel
// sweep_done_out   out  1        1-cycle pulse at end of each completed sweep
// BEHAVIOUR
// Reset, async on rst_n_in low:
// - state=IDLE; idx=0; all outputs 0; theta_q=dtheta_in captured on first cycle after release.
// FSM:
// - IDLE: mode_q<=mode_in; theta_q<=dtheta_in; idx<=0; ->SCAN.
// - SCAN, one idx per cycle:
//   - visible = OR over c of col_mask_in[idx+c*SCAN_RATE].
//   - Visible: src_col_idx_out<=idx; wait counter<=SRC_LATENCY; ->WAIT.
//   - Not visible and idx==SCAN_RATE-1: ->DONE.
//   - Otherwise idx++.
// - WAIT: counter decrements to 0, then ->CAPTURE.
//   - SRC_LATENCY=0 skips WAIT.
// - CAPTURE: columns_out[c] <= src_data_in[mode_q][c] if that channel's mask bit is set, else 0 (blank).
//   - col_num_out[c] <= idx + c*SCAN_RATE.
//   - data_valid_out<=1; ->OFFER.
//   - Latency: data_valid_out rises SRC_LATENCY+2 cycles after the SCAN cycle that found idx.
// - OFFER: columns_out and col_num_out held stable while data_valid_out=1.
//   - On data_valid_out & hub75_ready_in, the beat is accepted.
//   - data_valid_out deasserts next cycle, unless a new beat loads in CAPTURE.
//   - Then idx==SCAN_RATE-1 ? ->DONE : idx++ and ->SCAN.
// - DONE: sweep_done_out=1 for one cycle.
//   - loop_en_in=1 -> IDLE next cycle.
//   - loop_en_in=0: hold in DONE until dtheta_in != theta_q, then ->IDLE.
// dtheta change (dtheta_in != theta_q):
// - In SCAN/WAIT/CAPTURE: abort without emitting; ->IDLE next cycle; no sweep_done_out.
// - In OFFER: the pending beat still completes its handshake (never drops valid without ready).
//   - After acceptance ->IDLE, not SCAN.
// Simultaneous events:
// - ready and dtheta change in the same OFFER cycle: the beat is accepted, then ->IDLE.
// - mode_in change mid-sweep: ignored until next IDLE.
// Arithmetic and data widths:
// - idx wraps only via IDLE; idx+c*SCAN_RATE is computed in CW bits with no overflow.
// - col_mask_in is sampled live; the bit in use is the one present at the SCAN/CAPTURE cycle.
// - All-zero mask: the sweep takes SCAN_RATE cycles, emits no beats, and pulses sweep_done_out.
// Reset asserted mid-OFFER: data_valid_out drops immediately (async); no beat is considered accepted.
// TESTING
// 1. SRC_LATENCY=2, full mask, ready tied 1, mode 1:
//    - 32 beats; col_num_out = {0,32},{1,33}..{31,63}.
//    - First valid 4 cycles after the SCAN hit; sweep_done_out once.
// 2. Mask bits {5,37} and {20} only:
//    - Exactly 2 beats, col_num {5,37} then {20,52}.
//    - Channel1 of beat 2 is zero.
//    - No beat for other indices.
// 3. Backpressure: ready low 10 cycles during beat idx=3:
//    - valid, columns_out and col_num_out held for all 10 cycles.
//    - Accepted on the first ready cycle; next beat is idx=4.
// 4. dtheta 7->8 during WAIT for idx=9:
//    - No beat for idx=9; new sweep starts at idx 0 with theta_q=8; no sweep_done_out.
//    - Repeat with the change during OFFER: that beat completes, then restart.
// 5. loop_en_in=0 after sweep done:
//    - Stays in DONE, no valid, while dtheta is constant.
//    - dtheta change -> sweep restarts.
//    - mode_in change mid-sweep only takes effect next sweep.
// 6. rst_n_in pulsed low mid-OFFER:
//    - All outputs 0 asynchronously.
//    - After release, the sweep restarts from idx 0.
//    - Also check the all-zero mask sweep: 0 beats, one sweep_done_out.

Source files
------------

// File: rtl/col_stream_sequencer.sv
// Column streamer: sweeps scan indices for the current rotation slot, waits out the
// source pipeline, and hands each visible column beat to the hub75 driver via valid/ready.
module col_stream_sequencer #(
  parameter int ROTATIONAL_RES = 256,
  parameter int NUM_ROWS       = 64,
  parameter int SCAN_RATE      = 32,
  parameter int RGB_RES        = 9,
  parameter int NUM_CHANNELS   = 2,
  parameter int NUM_SOURCES    = 4,
  parameter int SRC_LATENCY    = 2,
  localparam int TW   = $clog2(ROTATIONAL_RES),
  localparam int IW   = $clog2(SCAN_RATE),
  localparam int CW   = $clog2(NUM_CHANNELS * SCAN_RATE),
  localparam int MW   = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1,
  localparam int COLW = NUM_ROWS * RGB_RES
) (
  input  logic                                     clk_in,
  input  logic                                     rst_n_in,
  input  logic [MW-1:0]                            mode_in,
  input  logic                                     loop_en_in,
  input  logic [TW-1:0]                            dtheta_in,
  input  logic [NUM_CHANNELS*SCAN_RATE-1:0]        col_mask_in,
  output logic [IW-1:0]                            src_col_idx_out,
  input  logic [NUM_SOURCES*NUM_CHANNELS*COLW-1:0] src_data_in,
  input  logic                                     hub75_ready_in,
  output logic                                     data_valid_out,
  output logic [NUM_CHANNELS*COLW-1:0]             columns_out,
  output logic [NUM_CHANNELS*CW-1:0]               col_num_out,
  output logic                                     sweep_done_out
);

  localparam int KW = (SRC_LATENCY > 0) ? $clog2(SRC_LATENCY + 1) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(SCAN_RATE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_WAIT, S_CAPTURE, S_OFFER, S_DONE
  } state_t;

  state_t                       state_q;
  logic [IW-1:0]                idx_q;
  logic [IW-1:0]                src_idx_q;
  logic [KW-1:0]                wait_cnt_q;
  logic [MW-1:0]                mode_q;
  logic [TW-1:0]                theta_q;
  logic                         valid_q;
  logic                         done_q;
  logic [NUM_CHANNELS*COLW-1:0] cols_q;
  logic [NUM_CHANNELS*CW-1:0]   nums_q;

  logic [NUM_CHANNELS*COLW-1:0] cols_d;
  logic [NUM_CHANNELS*CW-1:0]   nums_d;
  logic [NUM_CHANNELS-1:0]      chan_vis;
  logic [COLW-1:0]              src_arr [NUM_SOURCES][NUM_CHANNELS];
  logic                         visible;
  logic                         theta_chg;

  for (genvar s = 0; s < NUM_SOURCES; s++) begin : g_s
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_c
      assign src_arr[s][c] = src_data_in[(s*NUM_CHANNELS + c)*COLW +: COLW];
    end
  end

  // Channel c shows panel column idx + c*SCAN_RATE; blank channels whose mask bit is clear.
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    logic [CW-1:0] num;
    assign num                     = CW'(c * SCAN_RATE) + CW'(idx_q);
    assign chan_vis[c]             = col_mask_in[num];
    assign nums_d[c*CW +: CW]      = num;
    assign cols_d[c*COLW +: COLW]  = chan_vis[c] ? src_arr[mode_q][c] : '0;
  end

  always_comb begin
    visible   = |chan_vis;
    theta_chg = (dtheta_in != theta_q);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      src_idx_q  <= '0;
      wait_cnt_q <= '0;
      mode_q     <= '0;
      theta_q    <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      cols_q     <= '0;
      nums_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          mode_q  <= mode_in;
          theta_q <= dtheta_in;
          idx_q   <= '0;
          state_q <= S_SCAN;
        end
        S_SCAN: begin
          if (theta_chg) begin
            state_q <= S_IDLE;
          end else if (visible) begin
            src_idx_q <= idx_q;
            if (SRC_LATENCY == 0) begin
              state_q <= S_CAPTURE;
            end else begin
              wait_cnt_q <= KW'(SRC_LATENCY);
              state_q    <= S_WAIT;
            end
          end else if (idx_q == LAST_IDX) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        S_WAIT: begin
          if (theta_chg) begin
            state_q <= S_IDLE;
          end else if (wait_cnt_q == KW'(1)) begin
            state_q <= S_CAPTURE;
          end else begin
            wait_cnt_q <= wait_cnt_q - KW'(1);
          end
        end
        S_CAPTURE: begin
          if (theta_chg) begin
            state_q <= S_IDLE;
          end else begin
            cols_q  <= cols_d;
            nums_q  <= nums_d;
            valid_q <= 1'b1;
            state_q <= S_OFFER;
          end
        end
        // A pending beat always completes its handshake; a rotation change only redirects what follows.
        S_OFFER: begin
          if (hub75_ready_in) begin
            valid_q <= 1'b0;
            if (theta_chg) begin
              state_q <= S_IDLE;
            end else if (idx_q == LAST_IDX) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              idx_q   <= idx_q + IW'(1);
              state_q <= S_SCAN;
            end
          end
        end
        S_DONE: begin
          if (loop_en_in || theta_chg) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    src_col_idx_out = src_idx_q;
    data_valid_out  = valid_q;
    columns_out     = cols_q;
    col_num_out     = nums_q;
    sweep_done_out  = done_q;
  end

endmodule

// File: tb/tb_col_stream_sequencer.sv
// Bench for col_stream_sequencer: directed scenarios plus random masks/modes/ready, checked
// against a beat-list model built from mask, mode and a per-index source table.
module tb_col_stream_sequencer;
  localparam int RR = 256, NR = 4, SR = 32, RGB = 9, NC = 2, NS = 4, LAT = 2;
  localparam int TW = $clog2(RR), IW = $clog2(SR), CW = $clog2(NC*SR), MW = $clog2(NS);
  localparam int COLW = NR * RGB;

  typedef struct packed {
    logic [NC*COLW-1:0] cols;
    logic [NC*CW-1:0]   nums;
  } beat_t;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [MW-1:0]          mode;
  logic                   loop_en;
  logic [TW-1:0]          dtheta;
  logic [NC*SR-1:0]       mask;
  logic [IW-1:0]          src_idx;
  logic [NS*NC*COLW-1:0]  src_data;
  logic                   ready;
  logic                   valid;
  logic [NC*COLW-1:0]     cols;
  logic [NC*CW-1:0]       nums;
  logic                   done;

  always #5 clk = ~clk;

  col_stream_sequencer #(
    .ROTATIONAL_RES(RR), .NUM_ROWS(NR), .SCAN_RATE(SR), .RGB_RES(RGB),
    .NUM_CHANNELS(NC), .NUM_SOURCES(NS), .SRC_LATENCY(LAT)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n), .mode_in(mode), .loop_en_in(loop_en),
    .dtheta_in(dtheta), .col_mask_in(mask), .src_col_idx_out(src_idx),
    .src_data_in(src_data), .hub75_ready_in(ready), .data_valid_out(valid),
    .columns_out(cols), .col_num_out(nums), .sweep_done_out(done)
  );

  // Pipelined sources: data for an index appears LAT cycles after the index is presented.
  logic [COLW-1:0] tbl [NS][NC][SR];
  logic [IW-1:0]   d1 = '0, d2 = '0;
  always @(posedge clk) begin
    d1 <= src_idx;
    d2 <= d1;
  end
  always_comb begin
    src_data = '0;
    for (int s = 0; s < NS; s++)
      for (int c = 0; c < NC; c++)
        src_data[(s*NC + c)*COLW +: COLW] = tbl[s][c][d2];
  end

  int checks = 0, errors = 0;
  int dones = 0, last_ticks = 0, n;
  int ready_mode = 0, stall_idx = 0, stall_left = 0;
  int trig_kind = 0, trig_idx = 0;
  logic [TW-1:0]      trig_theta;
  logic [MW-1:0]      trig_mode;
  logic               pv = 1'b0, pr = 1'b0;
  logic [NC*COLW-1:0] pcols;
  logic [NC*CW-1:0]   pnums;
  beat_t              exp_q[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_tbl();
    for (int s = 0; s < NS; s++)
      for (int c = 0; c < NC; c++)
        for (int i = 0; i < SR; i++)
          tbl[s][c][i] = COLW'({$urandom, $urandom});
  endtask

  // Expected beats for indices first..last: one beat per index with any visible channel.
  function automatic void add_sweep(input int first, input int last,
                                    input logic [NC*SR-1:0] m, input int md);
    beat_t b;
    logic  any;
    for (int i = first; i <= last; i++) begin
      any = 1'b0;
      b   = '0;
      for (int c = 0; c < NC; c++) begin
        b.nums[c*CW +: CW] = CW'(i + c*SR);
        if (m[i + c*SR]) begin
          any = 1'b1;
          b.cols[c*COLW +: COLW] = tbl[md][c][i];
        end
      end
      if (any) exp_q.push_back(b);
    end
  endfunction

  task automatic tick();
    beat_t b;
    @(negedge clk);
    if (pv && !pr) begin
      chk("hold_valid", 128'(valid), 128'(1));
      chk("hold_data", 128'({cols, nums}), 128'({pcols, pnums}));
    end
    case (trig_kind)
      1: if (!valid && src_idx == IW'(trig_idx)) begin dtheta = trig_theta; trig_kind = 0; end
      2: if (valid && nums[CW-1:0] == CW'(trig_idx)) begin dtheta = trig_theta; trig_kind = 0; end
      3: if (valid && nums[CW-1:0] == CW'(trig_idx)) begin mode = trig_mode; trig_kind = 0; end
      default: ;
    endcase
    case (ready_mode)
      1: ready = 1'($urandom_range(0, 1));
      2: if (valid && nums[CW-1:0] == CW'(stall_idx) && stall_left > 0) begin
           ready = 1'b0;
           stall_left--;
         end else ready = 1'b1;
      default: ready = 1'b1;
    endcase
    if (valid && ready) begin
      chk("beat_expected", 128'(exp_q.size() != 0), 128'(1));
      if (exp_q.size() != 0) begin
        b = exp_q.pop_front();
        chk("beat", 128'({cols, nums}), 128'({b.cols, b.nums}));
      end
    end
    if (done) dones++;
    pv = valid; pr = ready; pcols = cols; pnums = nums;
  endtask

  task automatic run_to_done(input string tag, input int budget);
    int d0, k;
    d0 = dones;
    k  = 0;
    while (dones == d0 && k < budget) begin
      tick();
      k++;
    end
    last_ticks = k;
    chk({tag, "_done"}, 128'(dones - d0), 128'(1));
    chk({tag, "_beats_left"}, 128'(exp_q.size()), 128'(0));
    exp_q.delete();
    trig_kind = 0;
  endtask

  task automatic check_latency(input string tag);
    for (int k = 0; k < LAT + 2; k++) begin
      tick();
      chk({tag, "_lat_idle"}, 128'(valid), 128'(0));
    end
    tick();
    chk({tag, "_lat_valid"}, 128'(valid), 128'(1));
  endtask

  initial begin
    mode = 1; loop_en = 0; dtheta = 7; mask = '1; ready = 1;
    fill_tbl();
    repeat (3) @(negedge clk);
    chk("reset_outs", 128'({valid, done, src_idx, cols, nums}), 128'(0));

    // Full mask, ready always high
    add_sweep(0, SR-1, mask, 1);
    rst_n = 1;
    check_latency("t1");
    run_to_done("t1", 600);

    // Parked in DONE while rotation slot is unchanged
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("done_hold", 128'({valid, done}), 128'(0));
    end

    // Sparse mask: beats {5,37} and {20,52} with channel 1 blanked
    mask = '0; mask[5] = 1; mask[37] = 1; mask[20] = 1;
    add_sweep(0, SR-1, mask, 1);
    dtheta = 8;
    run_to_done("t2", 600);

    // Ten-cycle backpressure on idx 3
    mask = '1; ready_mode = 2; stall_idx = 3; stall_left = 10;
    add_sweep(0, SR-1, mask, 1);
    dtheta = 9;
    run_to_done("t3", 800);
    chk("t3_stall_used", 128'(stall_left), 128'(0));
    ready_mode = 0;

    // Rotation change during WAIT for idx 9: no beat 9, clean restart
    trig_kind = 1; trig_idx = 9; trig_theta = 8;
    add_sweep(0, 8, mask, 1);
    add_sweep(0, SR-1, mask, 1);
    dtheta = 7;
    run_to_done("t4a", 900);

    // Rotation change in OFFER coinciding with ready
    trig_kind = 2; trig_idx = 12; trig_theta = 10;
    add_sweep(0, 12, mask, 1);
    add_sweep(0, SR-1, mask, 1);
    dtheta = 9;
    run_to_done("t4b", 900);

    // Rotation change in OFFER while stalled
    trig_kind = 2; trig_idx = 20; trig_theta = 12;
    ready_mode = 2; stall_idx = 20; stall_left = 4;
    add_sweep(0, 20, mask, 1);
    add_sweep(0, SR-1, mask, 1);
    dtheta = 11;
    run_to_done("t4c", 900);
    ready_mode = 0;

    // Mode change mid-sweep applies only to the following sweep
    mode = 2; trig_kind = 3; trig_idx = 10; trig_mode = 3;
    add_sweep(0, SR-1, mask, 2);
    dtheta = 13;
    run_to_done("t5_mode_old", 600);
    chk("t5_mode_in", 128'(mode), 128'(3));
    add_sweep(0, SR-1, mask, 3);
    dtheta = 14;
    run_to_done("t5_mode_new", 600);

    // All-zero mask: IDLE + SCAN_RATE scan cycles, no beats, one done
    mask = '0;
    dtheta = 15;
    run_to_done("zero", 200);
    chk("zero_ticks", 128'(last_ticks), 128'(2 + SR));

    // Looping restarts right after DONE
    loop_en = 1;
    run_to_done("loop1", 200);
    chk("loop1_ticks", 128'(last_ticks), 128'(2 + SR));
    run_to_done("loop2", 200);
    chk("loop2_ticks", 128'(last_ticks), 128'(2 + SR));
    loop_en = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("loop_off_hold", 128'({valid, done}), 128'(0));
    end

    // Random masks, modes, source data and ready
    ready_mode = 1;
    for (int r = 0; r < 4; r++) begin
      mask = {$urandom, $urandom} & {$urandom, $urandom};
      mode = MW'($urandom_range(0, NS-1));
      fill_tbl();
      add_sweep(0, SR-1, mask, int'(mode));
      dtheta = TW'(20 + r);
      run_to_done("rand", 2000);
    end

    // Asynchronous reset while a beat is stalled in OFFER
    mask = '1; ready_mode = 2; stall_idx = 6; stall_left = 30;
    add_sweep(0, SR-1, mask, int'(mode));
    dtheta = 30;
    n = 0;
    while (!(valid && nums[CW-1:0] == CW'(6)) && n < 400) begin
      tick();
      n++;
    end
    chk("t6_reach_offer", 128'(valid), 128'(1));
    #2 rst_n = 0;
    #1 chk("t6_async_clear", 128'({valid, done, src_idx, cols, nums}), 128'(0));
    exp_q.delete();
    pv = 0; stall_left = 0; ready_mode = 0; ready = 1;
    @(negedge clk);
    chk("t6_in_reset", 128'({valid, done, src_idx, cols, nums}), 128'(0));
    add_sweep(0, SR-1, mask, int'(mode));
    rst_n = 1;
    check_latency("t6");
    run_to_done("t6", 600);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
